// File: rtl/uop_fetch_wide_pkg.sv
// Shared definitions for the uop buffer producer and consumer.
// Holds the default buffer geometry and the entry field-offset helpers so that
// both sides of the buffer pack and unpack entries with one layout.
// Entry layout, LSB first: LANES x 32b instructions, LANES x TAG_BITS tags,
// LANES lane-valid bits. Lane 0 is the lowest slice of each field.
package uop_fetch_wide_pkg;

    localparam int unsigned MAX_PREDICT_DEPTH_BITS = 4;
    localparam int unsigned UOP_BUF_SIZE           = 16;

    function automatic int unsigned entry_width(input int unsigned lanes,
                                                input int unsigned tag_bits);
        return lanes * (32 + tag_bits) + lanes;
    endfunction

    function automatic int unsigned instr_lsb(input int unsigned lane);
        return lane * 32;
    endfunction

    function automatic int unsigned tag_lsb(input int unsigned lanes,
                                            input int unsigned tag_bits,
                                            input int unsigned lane);
        return lanes * 32 + lane * tag_bits;
    endfunction

    function automatic int unsigned lane_valid_lsb(input int unsigned lanes,
                                                   input int unsigned tag_bits);
        return lanes * (32 + tag_bits);
    endfunction

endpackage

// File: rtl/uop_skid_buffer.sv
// Two-entry skid store with valid/ready handshakes on both sides.
// Ports:
//   clk, reset     - clock, asynchronous active-low reset
//   flush          - empties the store on the next edge, wins over push/pop
//   in_valid/in_ready/in_data    - write side (ready while fewer than 2 held)
//   out_valid/out_ready/out_data - read side, oldest entry first
module uop_skid_buffer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] mem_q [2];
    logic             head_q, head_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop, tail;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[head_q];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    // With one entry held the free slot is the one after the head.
    assign tail      = head_q ^ count_q[0];

    always_comb begin
        head_d  = head_q;
        count_d = count_q;
        if (flush) begin
            head_d  = 1'b0;
            count_d = 2'd0;
        end else begin
            if (pop) begin
                head_d = ~head_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q   <= 1'b0;
            count_q  <= 2'd0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
        end else begin
            head_q  <= head_d;
            count_q <= count_d;
            if (push && !flush) begin
                mem_q[tail] <= in_data;
            end
        end
    end

endmodule

// File: rtl/uop_fetch_wide.sv
// Wide uop fetch stage: reads LANES-wide entries from the uop buffer RAM
// (1-cycle read latency), drops entries with no valid lane, zeroes invalid
// lanes and presents bundles downstream with stall backpressure.
// Ports:
//   clk, reset        - clock, asynchronous active-low reset
//   clear, clear_ptr  - flush/redirect; read pointer reloaded from clear_ptr
//   wr_ptr            - producer write pointer (wrap bit in MSB)
//   rd_ptr            - consumer pointer (wrap bit in MSB)
//   uop_addr, uop_rd_en, uop - buffer RAM read port
//   next_stalled      - downstream cannot accept
//   valid, stalled    - bundle valid / bundle held by downstream stall
//   instruction, branch_tag, lane_valid - presented bundle, lane packed
module uop_fetch_wide
    import uop_fetch_wide_pkg::*;
#(
    parameter int unsigned LANES    = 2,
    parameter int unsigned TAG_BITS = MAX_PREDICT_DEPTH_BITS,
    parameter int unsigned BUF_SIZE = UOP_BUF_SIZE,
    localparam int unsigned ABITS   = $clog2(BUF_SIZE),
    localparam int unsigned ENTRY_W = entry_width(LANES, TAG_BITS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [ABITS:0]            clear_ptr,
    input  logic [ABITS:0]            wr_ptr,
    output logic [ABITS:0]            rd_ptr,
    output logic [ABITS-1:0]          uop_addr,
    output logic                      uop_rd_en,
    input  logic [ENTRY_W-1:0]        uop,
    input  logic                      next_stalled,
    output logic                      valid,
    output logic                      stalled,
    output logic [LANES*32-1:0]       instruction,
    output logic [LANES*TAG_BITS-1:0] branch_tag,
    output logic [LANES-1:0]          lane_valid
);

    localparam int unsigned TAG_LSB = tag_lsb(LANES, TAG_BITS, 0);
    localparam int unsigned LV_LSB  = lane_valid_lsb(LANES, TAG_BITS);

    logic [ABITS:0]     rd_ptr_q, rd_ptr_d;
    logic               inflight_q, inflight_d;
    logic               out_valid_q, out_valid_d;
    logic [ENTRY_W-1:0] out_data_q, out_data_d;

    logic [ENTRY_W-1:0] ret_data;
    logic               ret_valid;
    logic               empty, room, accept, out_load, bypass;
    logic               skid_in_valid, skid_in_ready, skid_out_valid;
    logic [ENTRY_W-1:0] skid_out_data;

    // Returned entry with invalid lanes zeroed.
    always_comb begin
        ret_data = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (uop[LV_LSB + l]) begin
                ret_data[instr_lsb(l) +: 32] = uop[instr_lsb(l) +: 32];
                ret_data[tag_lsb(LANES, TAG_BITS, l) +: TAG_BITS] =
                    uop[tag_lsb(LANES, TAG_BITS, l) +: TAG_BITS];
                ret_data[LV_LSB + l] = 1'b1;
            end
        end
    end

    // Entries with no valid lane are dropped here; their read still counted.
    assign ret_valid = inflight_q && (|ret_data[LV_LSB +: LANES]) && !clear;

    assign empty    = (rd_ptr_q == wr_ptr);
    assign accept   = out_valid_q && !next_stalled;
    assign out_load = !out_valid_q || accept;
    // Straight into the output register when nothing older is queued.
    assign bypass   = out_load && !skid_out_valid;

    assign skid_in_valid = ret_valid && !bypass;

    // Skid occupancy + in-flight read must stay below 2: with a read in
    // flight the skid must be empty, otherwise it needs a free slot.
    assign room      = inflight_q ? !skid_out_valid : skid_in_ready;
    assign uop_rd_en = reset && !empty && !clear && room;

    uop_skid_buffer #(
        .WIDTH (ENTRY_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (clear),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .in_data   (ret_data),
        .out_valid (skid_out_valid),
        .out_ready (out_load),
        .out_data  (skid_out_data)
    );

    always_comb begin
        rd_ptr_d    = rd_ptr_q + {{ABITS{1'b0}}, uop_rd_en};
        inflight_d  = uop_rd_en;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (clear) begin
            rd_ptr_d    = clear_ptr;
            inflight_d  = 1'b0;
            out_valid_d = 1'b0;
        end else if (out_load) begin
            if (skid_out_valid) begin
                out_valid_d = 1'b1;
                out_data_d  = skid_out_data;
            end else if (ret_valid) begin
                out_valid_d = 1'b1;
                out_data_d  = ret_data;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q    <= '0;
            inflight_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            inflight_q  <= inflight_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign rd_ptr      = rd_ptr_q;
    assign uop_addr    = rd_ptr_q[ABITS-1:0];
    assign valid       = out_valid_q;
    assign stalled     = out_valid_q && next_stalled;
    assign instruction = out_valid_q ? out_data_q[0 +: LANES*32] : '0;
    assign branch_tag  = out_valid_q ? out_data_q[TAG_LSB +: LANES*TAG_BITS] : '0;
    assign lane_valid  = out_valid_q ? out_data_q[LV_LSB +: LANES] : '0;

endmodule

// File: tb/tb_uop_fetch_wide.sv
// Directed bench for uop_fetch_wide (LANES=2, TAG_BITS=4; BUF_SIZE 16 and 4).
module tb_uop_fetch_wide;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    // BUF_SIZE = 16 instance
    logic        clear = 1'b0;
    logic [4:0]  clear_ptr = '0;
    logic [4:0]  wr_ptr = '0;
    logic [4:0]  rd_ptr;
    logic [3:0]  uop_addr;
    logic        uop_rd_en;
    logic [73:0] uop = '0;
    logic        next_stalled = 1'b0;
    logic        valid, stalled;
    logic [63:0] instruction;
    logic [7:0]  branch_tag;
    logic [1:0]  lane_valid;
    logic [73:0] mem [16];

    // BUF_SIZE = 4 instance
    logic        clear4 = 1'b0;
    logic [2:0]  clear_ptr4 = '0;
    logic [2:0]  wr_ptr4 = '0;
    logic [2:0]  rd_ptr4;
    logic [1:0]  uop_addr4;
    logic        uop_rd_en4;
    logic [73:0] uop4 = '0;
    logic        next_stalled4 = 1'b0;
    logic        valid4, stalled4;
    logic [63:0] instruction4;
    logic [7:0]  branch_tag4;
    logic [1:0]  lane_valid4;
    logic [73:0] mem4 [4];

    int checks = 0;
    int errors = 0;

    int         exp_q [64];
    int         exp_rd [64];
    bit         stall_q [64];
    int         clear_at;
    logic [4:0] clear_ptr_v;
    logic [4:0] clear_wr_v;

    always #5 clk = ~clk;

    uop_fetch_wide dut (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear),
        .clear_ptr    (clear_ptr),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .uop_addr     (uop_addr),
        .uop_rd_en    (uop_rd_en),
        .uop          (uop),
        .next_stalled (next_stalled),
        .valid        (valid),
        .stalled      (stalled),
        .instruction  (instruction),
        .branch_tag   (branch_tag),
        .lane_valid   (lane_valid)
    );

    uop_fetch_wide #(
        .BUF_SIZE (4)
    ) dut4 (
        .clk          (clk),
        .reset        (reset),
        .clear        (clear4),
        .clear_ptr    (clear_ptr4),
        .wr_ptr       (wr_ptr4),
        .rd_ptr       (rd_ptr4),
        .uop_addr     (uop_addr4),
        .uop_rd_en    (uop_rd_en4),
        .uop          (uop4),
        .next_stalled (next_stalled4),
        .valid        (valid4),
        .stalled      (stalled4),
        .instruction  (instruction4),
        .branch_tag   (branch_tag4),
        .lane_valid   (lane_valid4)
    );

    // Buffer RAMs: synchronous read, data valid the cycle after the strobe.
    always @(posedge clk) if (uop_rd_en) uop <= mem[uop_addr];
    always @(posedge clk) if (uop_rd_en4) uop4 <= mem4[uop_addr4];

    task automatic check_eq(input string tag, input logic [127:0] got,
                            input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entry layout: {lv[1:0], tag1, tag0, instr1, instr0}
    function automatic logic [73:0] ent(input logic [31:0] k, input logic [1:0] lv);
        logic [3:0] t;
        t = k[3:0];
        return {lv, ~t, t, 32'hB000_0000 | k, 32'hA000_0000 | k};
    endfunction

    // Expected bundle {lane_valid, branch_tag, instruction} for an entry.
    function automatic logic [73:0] present(input logic [73:0] e);
        logic [73:0] r;
        r = '0;
        r[73:72] = e[73:72];
        if (e[72]) begin
            r[31:0]  = e[31:0];
            r[67:64] = e[67:64];
        end
        if (e[73]) begin
            r[63:32] = e[63:32];
            r[71:68] = e[71:68];
        end
        return r;
    endfunction

    task automatic clear_tables();
        for (int i = 0; i < 64; i++) begin
            exp_q[i]   = -1;
            exp_rd[i]  = -1;
            stall_q[i] = 1'b0;
        end
        clear_at = -1;
    endtask

    // Entered just after a rising edge; that edge starts cycle 0.
    task automatic run(input int n, input string name);
        for (int c = 0; c < n; c++) begin
            next_stalled = stall_q[c];
            if (c == clear_at) begin
                clear     = 1'b1;
                clear_ptr = clear_ptr_v;
                wr_ptr    = clear_wr_v;
            end else begin
                clear = 1'b0;
            end
            @(negedge clk);
            check_eq($sformatf("%s c%0d valid", name, c), valid, exp_q[c] >= 0);
            check_eq($sformatf("%s c%0d stalled", name, c), stalled,
                     (exp_q[c] >= 0) && stall_q[c]);
            check_eq($sformatf("%s c%0d bundle", name, c),
                     {lane_valid, branch_tag, instruction},
                     (exp_q[c] >= 0) ? present(mem[exp_q[c]]) : 74'd0);
            if (exp_rd[c] == -2) begin
                check_eq($sformatf("%s c%0d no strobe", name, c), uop_rd_en, 1'b0);
            end else if (exp_rd[c] >= 0) begin
                check_eq($sformatf("%s c%0d strobe", name, c), uop_rd_en, 1'b1);
                check_eq($sformatf("%s c%0d addr", name, c), uop_addr, exp_rd[c]);
            end
            @(posedge clk);
            #1;
        end
        clear        = 1'b0;
        next_stalled = 1'b0;
    endtask

    initial begin
        int wr_cnt, got, strobes;
        logic [2:0] occ;

        for (int i = 0; i < 16; i++) mem[i] = '0;
        for (int i = 0; i < 4; i++) mem4[i] = '0;

        // Reset values, asserted away from the clock edge
        #2 reset = 1'b0;
        #1;
        check_eq("reset valid", valid, 1'b0);
        check_eq("reset rd_ptr", rd_ptr, 5'd0);
        check_eq("reset rd_en", uop_rd_en, 1'b0);
        check_eq("reset bundle", {lane_valid, branch_tag, instruction}, 74'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Four entries, no stall: strobe at cycle 0, valid cycles 2..5
        clear_tables();
        for (int k = 0; k < 4; k++) mem[k] = ent(k, 2'b11);
        wr_ptr = 5'd4;
        exp_rd[0] = 0;
        for (int c = 2; c <= 5; c++) exp_q[c] = c - 2;
        run(8, "basic");
        check_eq("basic rd_ptr", rd_ptr, 5'd4);

        // Eight entries, stall in cycles 3..6, mixed lane masks
        clear_tables();
        for (int k = 0; k < 8; k++)
            mem[4 + k] = ent(16 + k, (k % 3 == 0) ? 2'b01 : (k % 3 == 1) ? 2'b10 : 2'b11);
        wr_ptr = 5'd12;
        for (int c = 3; c <= 6; c++) stall_q[c] = 1'b1;
        exp_q[2] = 4;
        for (int c = 3; c <= 7; c++) exp_q[c] = 5;
        for (int c = 8; c <= 13; c++) exp_q[c] = c - 2;
        run(16, "stall");
        check_eq("stall rd_ptr", rd_ptr, 5'd12);

        // Empty-lane entry between two valid ones
        clear_tables();
        mem[12] = ent(40, 2'b11);
        mem[13] = ent(41, 2'b00);
        mem[14] = ent(42, 2'b11);
        wr_ptr = 5'd15;
        for (int c = 0; c <= 4; c++) stall_q[c] = 1'b1;
        for (int c = 2; c <= 5; c++) exp_q[c] = 12;
        exp_q[6] = 14;
        run(8, "drop");
        check_eq("drop rd_ptr", rd_ptr, 5'd15);

        // Clear with two held and one in flight, redirect to 5
        clear_tables();
        mem[15] = ent(50, 2'b11);
        mem[0]  = ent(51, 2'b11);
        mem[1]  = ent(52, 2'b11);
        mem[2]  = ent(53, 2'b11);
        mem[5]  = ent(60, 2'b10);
        mem[6]  = ent(61, 2'b01);
        wr_ptr = 5'd19;
        for (int c = 0; c <= 3; c++) stall_q[c] = 1'b1;
        clear_at    = 3;
        clear_ptr_v = 5'd5;
        clear_wr_v  = 5'd7;
        exp_q[2] = 15;
        exp_q[3] = 15;
        exp_q[6] = 5;
        exp_q[7] = 6;
        exp_rd[3] = -2;
        exp_rd[4] = 5;
        run(10, "clear");
        check_eq("clear rd_ptr", rd_ptr, 5'd7);

        // Reset asserted mid-stall, between clock edges
        clear_tables();
        mem[7] = ent(70, 2'b11);
        mem[8] = ent(71, 2'b11);
        mem[9] = ent(72, 2'b11);
        wr_ptr = 5'd10;
        for (int c = 0; c < 4; c++) stall_q[c] = 1'b1;
        exp_q[2] = 7;
        exp_q[3] = 7;
        run(4, "prerst");
        next_stalled = 1'b1;
        #2 reset = 1'b0;
        #1;
        check_eq("midrst valid", valid, 1'b0);
        check_eq("midrst stalled", stalled, 1'b0);
        check_eq("midrst rd_ptr", rd_ptr, 5'd0);
        check_eq("midrst addr", uop_addr, 4'd0);
        check_eq("midrst rd_en", uop_rd_en, 1'b0);
        check_eq("midrst bundle", {lane_valid, branch_tag, instruction}, 74'd0);
        wr_ptr = 5'd0;
        next_stalled = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check_eq("postrst rd_en", uop_rd_en, 1'b0);
        check_eq("postrst valid", valid, 1'b0);
        @(posedge clk);
        #1;
        clear_tables();
        wr_ptr = 5'd1;
        exp_rd[0] = 0;
        exp_q[2] = 0;
        run(5, "resume");

        // BUF_SIZE=4: ten entries through a four-slot buffer, pointer wraps
        wr_cnt  = 0;
        got     = 0;
        strobes = 0;
        for (int c = 0; c < 40; c++) begin
            occ = wr_ptr4 - rd_ptr4;
            if (wr_cnt < 10 && occ < 3'd4) begin
                mem4[wr_ptr4[1:0]] = ent(100 + wr_cnt, 2'b11);
                wr_ptr4 = wr_ptr4 + 3'd1;
                wr_cnt++;
            end
            @(negedge clk);
            if (uop_rd_en4) begin
                check_eq($sformatf("wrap ptr %0d", strobes), rd_ptr4, strobes % 8);
                check_eq($sformatf("wrap addr %0d", strobes), uop_addr4, strobes % 4);
                strobes++;
            end
            if (valid4) begin
                check_eq($sformatf("wrap data %0d", got),
                         {lane_valid4, branch_tag4, instruction4},
                         present(ent(100 + got, 2'b11)));
                got++;
            end
            @(posedge clk);
            #1;
        end
        check_eq("wrap delivered", got, 10);
        check_eq("wrap strobes", strobes, 10);
        check_eq("wrap final rd_ptr", rd_ptr4, 3'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uop_fetch_wide.md
UOP_FETCH_WIDE -- requirements
Module: uop_fetch_wide

Interface
REQ-001 SHALL have parameter LANES, default 2: instructions per uop entry, 1..8.
REQ-002 SHALL have parameter TAG_BITS, default MAX_PREDICT_DEPTH_BITS: branch tag width per lane.
REQ-003 SHALL have parameter BUF_SIZE, default UOP_BUF_SIZE: entry count, power of two; ABITS = $clog2(BUF_SIZE).
REQ-004 SHALL have derived ENTRY_W = LANES*(32+TAG_BITS)+LANES. Entry layout, LSB first: LANES x 32b instructions (lane 0 lowest), LANES x TAG_BITS tags (lane 0 lowest), LANES lane-valid bits.
REQ-005 Port clk, input, 1: single clock, rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-low reset.
REQ-007 Port clear, input, 1: pipeline flush/redirect.
REQ-008 Port clear_ptr, input, ABITS+1: read pointer loaded on clear, wrap bit in MSB.
REQ-009 Port wr_ptr, input, ABITS+1: producer write pointer, wrap bit in MSB.
REQ-010 Port rd_ptr, output, ABITS+1: consumer pointer; entries below it may be overwritten.
REQ-011 Port uop_addr, output, ABITS: buffer read address, equal to rd_ptr[ABITS-1:0].
REQ-012 Port uop_rd_en, output, 1: read strobe.
REQ-013 Port uop, input, ENTRY_W: read data for the address strobed in the previous cycle.
REQ-014 Port next_stalled, input, 1: downstream cannot accept.
REQ-015 Port valid, output, 1: output bundle valid.
REQ-016 Port stalled, output, 1: valid && next_stalled, i.e. bundle held.
REQ-017 Port instruction, output, LANES*32: lane-packed instructions.
REQ-018 Port branch_tag, output, LANES*TAG_BITS: lane-packed tags.
REQ-019 Port lane_valid, output, LANES: per-lane valid.

Function
REQ-020 Empty SHALL be rd_ptr == wr_ptr (all ABITS+1 bits); full-buffer state is the producer's concern.
REQ-021 uop_rd_en SHALL assert iff !empty && !clear && (held entries + in-flight reads) < 2; each strobe increments rd_ptr by 1, modulo 2*BUF_SIZE.
REQ-022 Read latency SHALL be 1 cycle: data is captured at the end of the cycle after the strobe. A bundle is accepted in each cycle where valid && !next_stalled.
REQ-023 An entry written with wr_ptr advanced before cycle 0 SHALL give strobe in cycle 0 and valid in cycle 2.
REQ-024 A 2-entry skid store SHALL absorb in-flight data when next_stalled rises; no entry is lost or duplicated; order is preserved.
REQ-025 With next_stalled low and the buffer non-empty, throughput SHALL be one entry per cycle.
REQ-026 While stalled, instruction, branch_tag and lane_valid SHALL stay stable.
REQ-027 Entries with all lane-valid bits 0 SHALL be dropped (never presented); they still consume rd_ptr.
REQ-028 Lanes with lane_valid=0 SHALL output instruction 0 and tag 0.
REQ-029 clear SHALL take priority over all else: next cycle valid=0, skid store empty, in-flight read discarded, rd_ptr=clear_ptr, no strobe in the clear cycle.
REQ-030 Read data returning in the cycle after clear SHALL be discarded.
REQ-031 Pointer wrap from 2*BUF_SIZE-1 to 0 SHALL be seamless, with uop_addr wrapping BUF_SIZE-1 to 0.

Reset
REQ-032 On reset low, immediately and independent of clk: valid=0, stalled=0, rd_ptr=0, uop_addr=0, uop_rd_en=0, instruction=0, branch_tag=0, lane_valid=0; skid store and in-flight flag cleared.
REQ-033 Reset asserted mid-stream SHALL discard all held and in-flight entries; after release, operation resumes from rd_ptr=0.

Structure
REQ-034 MAX_PREDICT_DEPTH_BITS, UOP_BUF_SIZE and the entry field-offset functions SHALL live in the shared defines package, so producer and consumer use one layout.
REQ-035 The 2-entry skid store SHALL be the sub-module uop_skid_buffer, parametrised by payload width, with valid/ready ports and a flush input.

Verification
REQ-036 LANES=2, write 4 entries at cycle 0, next_stalled=0 -> valid in cycles 2..5 with entries in order, then valid=0.
REQ-037 Stream 8 entries, next_stalled high for cycles 3..6 -> stalled=1 and outputs frozen for cycles 3..6; all 8 entries delivered exactly once, in order.
REQ-038 Entry lane_valid=2'b00 between two valid entries -> only the two valid entries presented, back-to-back; rd_ptr advances by 3.
REQ-039 clear with clear_ptr=5 while 2 entries held and 1 in flight -> next cycle valid=0; the next strobe uses uop_addr=5; no stale entry appears.
REQ-040 BUF_SIZE=4, stream 10 entries -> rd_ptr steps 0..7 then 0,1; the entries presented match the written data.
REQ-041 reset low mid-stall, asynchronous to clk -> all outputs 0 before the next edge; after release, fetch resumes from address 0.
